// File: rtl/player_hit_tracker.sv
// ---------------------------------------------------------------------------
// player_hit_tracker
//
// Frame-rate damage tracker. Once per video frame (on the end of vsync) the
// player bounding box is tested against the two NPC boxes. Contact removes
// one life, then a fixed number of frames of immunity follows. The block is
// the single registered source of player life, blink and dead flags for the
// mapper.
//
// Ports:
//   Clk, Reset          50 MHz clock, synchronous active-high reset
//   frame_vs            VGA vsync, active low, phase-asynchronous to Clk
//   Player_*            player box centre and half-extents (pixels)
//   EnemyV_*, EnemyH_*  NPC box centres and half-extents (pixels)
//   Enemy_Active        [0] enables NPC_V contact, [1] enables NPC_H contact
//   Respawn             level request, acted on only while dead
//   Player_Life         current life
//   Hit_Pulse           one-cycle pulse when a life is removed
//   Hit_Source          enemies overlapping at the last applied hit ([0]=V)
//   Invuln, Blink, Dead state flags for the mapper
//
// Latency from the vsync rising edge to state/life/pulse outputs is 5 Clk:
// 2 synchronizer flops + tick register, the overlap register, the FSM.
// ---------------------------------------------------------------------------

// Per-enemy box overlap. Distances are 11-bit magnitudes, the extent sums are
// 11-bit so they cannot wrap. Strict compare: touching edges do not count.
module player_hit_overlap (
   input  logic [9:0] px,
   input  logic [9:0] py,
   input  logic [9:0] psx,
   input  logic [9:0] psy,
   input  logic [9:0] ex,
   input  logic [9:0] ey,
   input  logic [9:0] esx,
   input  logic [9:0] esy,
   input  logic       en,
   output logic       hit
);
   logic [10:0] dx, dy, sx, sy;

   assign dx  = (px >= ex) ? {1'b0, px - ex} : {1'b0, ex - px};
   assign dy  = (py >= ey) ? {1'b0, py - ey} : {1'b0, ey - py};
   assign sx  = {1'b0, psx} + {1'b0, esx};
   assign sy  = {1'b0, psy} + {1'b0, esy};
   assign hit = en & (dx < sx) & (dy < sy);
endmodule

module player_hit_tracker #(
   parameter int LIFE_MAX      = 5,
   parameter int INVULN_FRAMES = 60
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_vs,
   input  logic [9:0] Player_X,
   input  logic [9:0] Player_Y,
   input  logic [9:0] Player_Size_X,
   input  logic [9:0] Player_Size_Y,
   input  logic [9:0] EnemyV_X,
   input  logic [9:0] EnemyV_Y,
   input  logic [9:0] EnemyV_Size_X,
   input  logic [9:0] EnemyV_Size_Y,
   input  logic [9:0] EnemyH_X,
   input  logic [9:0] EnemyH_Y,
   input  logic [9:0] EnemyH_Size_X,
   input  logic [9:0] EnemyH_Size_Y,
   input  logic [1:0] Enemy_Active,
   input  logic       Respawn,
   output logic [3:0] Player_Life,
   output logic       Hit_Pulse,
   output logic [1:0] Hit_Source,
   output logic       Invuln,
   output logic       Blink,
   output logic       Dead
);
   localparam int         NUM_ENEMY = 2;
   localparam logic [7:0] CNT_INIT  = 8'(INVULN_FRAMES - 1);
   localparam logic [3:0] LIFE_INIT = 4'(LIFE_MAX);

   typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

   // ---------------- frame tick ----------------
   // All three flops reset high so a low vsync at reset cannot produce a tick.
   logic       vs_s1, vs_s2, vs_d;
   logic       tick_raw;
   logic [1:0] vld_pipe;   // [0] tick, [1] ov valid (FSM evaluation cycle)

   assign tick_raw = vs_s2 & ~vs_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_s1    <= 1'b1;
         vs_s2    <= 1'b1;
         vs_d     <= 1'b1;
         vld_pipe <= '0;
      end else begin
         vs_s1    <= frame_vs;
         vs_s2    <= vs_s1;
         vs_d     <= vs_s2;
         vld_pipe <= {vld_pipe[0], tick_raw};
      end
   end

   // ---------------- overlap ----------------
   logic [NUM_ENEMY-1:0][9:0] e_x, e_y, e_sx, e_sy;
   logic [NUM_ENEMY-1:0]      ov_now;
   logic [NUM_ENEMY-1:0]      ov;

   assign e_x  = {EnemyH_X,      EnemyV_X};
   assign e_y  = {EnemyH_Y,      EnemyV_Y};
   assign e_sx = {EnemyH_Size_X, EnemyV_Size_X};
   assign e_sy = {EnemyH_Size_Y, EnemyV_Size_Y};

   genvar g;
   generate
      for (g = 0; g < NUM_ENEMY; g++) begin : g_enemy
         player_hit_overlap u_ov (
            .px  (Player_X),
            .py  (Player_Y),
            .psx (Player_Size_X),
            .psy (Player_Size_Y),
            .ex  (e_x[g]),
            .ey  (e_y[g]),
            .esx (e_sx[g]),
            .esy (e_sy[g]),
            .en  (Enemy_Active[g]),
            .hit (ov_now[g])
         );
      end
   endgenerate

   // Positions are only looked at on the tick; ov is frozen for the frame.
   always_ff @(posedge Clk) begin
      if (Reset)            ov <= '0;
      else if (vld_pipe[0]) ov <= ov_now;
   end

   // ---------------- life FSM ----------------
   state_t     st;
   logic [7:0] cnt;
   logic [7:0] cnt_dec;
   logic [3:0] life_dec;

   assign cnt_dec  = cnt - 8'd1;
   assign life_dec = Player_Life - 4'd1;

   // Outputs are written together with the state so they all move on the
   // same edge; Blink follows bit 2 of the value cnt is being loaded with.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         st          <= ALIVE;
         cnt         <= '0;
         Player_Life <= LIFE_INIT;
         Hit_Pulse   <= 1'b0;
         Hit_Source  <= '0;
         Invuln      <= 1'b0;
         Blink       <= 1'b0;
         Dead        <= 1'b0;
      end else begin
         Hit_Pulse <= 1'b0;
         case (st)
            ALIVE: begin
               if (vld_pipe[1] && ov != '0) begin
                  Player_Life <= life_dec;
                  Hit_Pulse   <= 1'b1;
                  Hit_Source  <= ov;
                  if (life_dec == 4'd0) begin
                     st   <= DEAD;
                     Dead <= 1'b1;
                  end else begin
                     st     <= INVULN;
                     cnt    <= CNT_INIT;
                     Invuln <= 1'b1;
                     Blink  <= CNT_INIT[2];
                  end
               end
            end
            INVULN: begin
               // The tick that ends immunity is itself ignored.
               if (vld_pipe[1]) begin
                  if (cnt != 8'd0) begin
                     cnt   <= cnt_dec;
                     Blink <= cnt_dec[2];
                  end else begin
                     st     <= ALIVE;
                     Invuln <= 1'b0;
                     Blink  <= 1'b0;
                  end
               end
            end
            DEAD: begin
               if (Respawn) begin
                  st          <= ALIVE;
                  Player_Life <= LIFE_INIT;
                  cnt         <= '0;
                  Hit_Source  <= '0;
                  Dead        <= 1'b0;
               end
            end
            default: begin
               st     <= ALIVE;
               Invuln <= 1'b0;
               Blink  <= 1'b0;
               Dead   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_player_hit_tracker.sv
// ---------------------------------------------------------------------------
// tb_player_hit_tracker
//
// Directed bench for player_hit_tracker with default parameters
// (LIFE_MAX=5, INVULN_FRAMES=60). Expected values are written by hand.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_player_hit_tracker;
   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_vs;
   logic [9:0] Player_X, Player_Y, Player_Size_X, Player_Size_Y;
   logic [9:0] EnemyV_X, EnemyV_Y, EnemyV_Size_X, EnemyV_Size_Y;
   logic [9:0] EnemyH_X, EnemyH_Y, EnemyH_Size_X, EnemyH_Size_Y;
   logic [1:0] Enemy_Active;
   logic       Respawn;
   logic [3:0] Player_Life;
   logic       Hit_Pulse;
   logic [1:0] Hit_Source;
   logic       Invuln, Blink, Dead;

   int checks = 0;
   int errors = 0;
   int npulse, first_at, total;

   always #10 Clk = ~Clk;

   player_hit_tracker dut (
      .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs),
      .Player_X(Player_X), .Player_Y(Player_Y),
      .Player_Size_X(Player_Size_X), .Player_Size_Y(Player_Size_Y),
      .EnemyV_X(EnemyV_X), .EnemyV_Y(EnemyV_Y),
      .EnemyV_Size_X(EnemyV_Size_X), .EnemyV_Size_Y(EnemyV_Size_Y),
      .EnemyH_X(EnemyH_X), .EnemyH_Y(EnemyH_Y),
      .EnemyH_Size_X(EnemyH_Size_X), .EnemyH_Size_Y(EnemyH_Size_Y),
      .Enemy_Active(Enemy_Active), .Respawn(Respawn),
      .Player_Life(Player_Life), .Hit_Pulse(Hit_Pulse), .Hit_Source(Hit_Source),
      .Invuln(Invuln), .Blink(Blink), .Dead(Dead)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One vsync frame: low for 3 cycles, then rise and watch 8 cycles.
   // first_at is the cycle (1-based) after the rise where Hit_Pulse is seen.
   task automatic frame();
      frame_vs = 1'b0;
      repeat (3) @(negedge Clk);
      frame_vs = 1'b1;
      npulse   = 0;
      first_at = -1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge Clk);
         if (Hit_Pulse === 1'b1) begin
            npulse++;
            if (first_at < 0) first_at = i;
         end
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      Reset = 1'b1; frame_vs = 1'b1; Respawn = 1'b0;
      Player_X = 100; Player_Y = 100; Player_Size_X = 8; Player_Size_Y = 8;
      EnemyV_X = 300; EnemyV_Y = 300; EnemyV_Size_X = 8; EnemyV_Size_Y = 8;
      EnemyH_X = 500; EnemyH_Y = 400; EnemyH_Size_X = 8; EnemyH_Size_Y = 8;
      Enemy_Active = 2'b11;
      do_reset();

      // reset state
      check("rst_life",   Player_Life, 5);
      check("rst_pulse",  Hit_Pulse,   0);
      check("rst_src",    Hit_Source,  0);
      check("rst_invuln", Invuln,      0);
      check("rst_blink",  Blink,       0);
      check("rst_dead",   Dead,        0);

      // 10 frames, no contact
      total = 0;
      for (int f = 0; f < 10; f++) begin
         frame();
         total += npulse;
      end
      check("idle_pulses", total, 0);
      check("idle_life", Player_Life, 5);
      check("idle_flags", {Invuln, Blink, Dead}, 0);

      // first hit from NPC_V
      EnemyV_X = 110; EnemyV_Y = 100;
      frame();
      check("hit1_npulse", npulse, 1);
      check("hit1_latency", first_at, 5);
      check("hit1_life", Player_Life, 4);
      check("hit1_src", Hit_Source, 1);
      check("hit1_invuln", Invuln, 1);
      check("hit1_blink_c59", Blink, 0);

      // Keep overlapping: 59 immune ticks walk cnt 58..0, blink = cnt[2]
      total = 0;
      for (int k = 1; k <= 59; k++) begin
         frame();
         total += npulse;
         if (k == 3)  check("blink_c56", Blink, 0);
         if (k == 4)  check("blink_c55", Blink, 1);
         if (k == 7)  check("blink_c52", Blink, 1);
         if (k == 8)  check("blink_c51", Blink, 0);
         if (k == 12) check("blink_c47", Blink, 1);
         if (k == 59) check("blink_c0", Blink, 0);
      end
      check("invuln_nopulse", total, 0);
      check("invuln_still", Invuln, 1);
      check("invuln_life", Player_Life, 4);
      // tick 60: immunity ends, overlap ignored
      frame();
      check("t60_npulse", npulse, 0);
      check("t60_invuln", Invuln, 0);
      check("t60_life", Player_Life, 4);
      // tick 61: hit again
      frame();
      check("t61_npulse", npulse, 1);
      check("t61_life", Player_Life, 3);
      check("t61_invuln", Invuln, 1);

      // reset landing on a tick in INVULN
      frame_vs = 1'b0;
      repeat (3) @(negedge Clk);
      frame_vs = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      npulse = 0;
      for (int i = 0; i < 5; i++) begin
         if (Hit_Pulse === 1'b1) npulse++;
         @(negedge Clk);
      end
      check("rstinv_pulses", npulse, 0);
      check("rstinv_life", Player_Life, 5);
      check("rstinv_invuln", Invuln, 0);
      check("rstinv_blink", Blink, 0);

      // edge touch on NPC_H: |dx| = 16 = sum, no hit
      EnemyV_X = 300; EnemyV_Y = 300;
      EnemyH_X = 116; EnemyH_Y = 100;
      frame();
      check("touch_npulse", npulse, 0);
      check("touch_life", Player_Life, 5);
      EnemyH_X = 115;
      frame();
      check("h_npulse", npulse, 1);
      check("h_life", Player_Life, 4);
      check("h_src", Hit_Source, 2);
      do_reset();

      // both NPCs in the same frame cost one life
      EnemyV_X = 110; EnemyV_Y = 100;
      frame();
      check("both_npulse", npulse, 1);
      check("both_life", Player_Life, 4);
      check("both_src", Hit_Source, 3);
      do_reset();
      Enemy_Active = 2'b00;
      frame();
      check("inactive_npulse", npulse, 0);
      check("inactive_life", Player_Life, 5);

      // five spaced hits from NPC_V alone down to DEAD
      Enemy_Active = 2'b01;
      for (int h = 1; h <= 5; h++) begin
         frame();
         check("kill_npulse", npulse, 1);
         check("kill_life", Player_Life, 5 - h);
         if (h < 5) begin
            total = 0;
            for (int k = 0; k < 60; k++) begin
               frame();
               total += npulse;
            end
            check("kill_gap_pulses", total, 0);
         end
      end
      check("dead_flag", Dead, 1);
      check("dead_invuln", Invuln, 0);
      check("dead_src", Hit_Source, 1);
      total = 0;
      for (int f = 0; f < 3; f++) begin
         frame();
         total += npulse;
      end
      check("dead_pulses", total, 0);
      check("dead_life", Player_Life, 0);
      check("dead_hold", Dead, 1);

      // respawn for one cycle
      Respawn = 1'b1;
      @(negedge Clk);
      Respawn = 1'b0;
      check("resp_life", Player_Life, 5);
      check("resp_dead", Dead, 0);
      check("resp_src", Hit_Source, 0);
      check("resp_invuln", Invuln, 0);
      frame();
      check("resp_alive_hit", npulse, 1);
      check("resp_alive_life", Player_Life, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // hard stop so the bench can never hang
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
